// File: rtl/cpu_timing_pkg.sv
// Shared definitions for the CPU timing generator and the control decoder.
//   phase_t     : registered timing phase codes (RESET..HALTED)
//   GRP_*       : instruction group codes presented on `group`
//   group_of()  : maps the two top instruction bits to a group code
package cpu_timing_pkg;

  typedef enum logic [2:0] {
    PH_RESET  = 3'd0,
    PH_FETCH  = 3'd1,
    PH_DECODE = 3'd2,
    PH_EXEC   = 3'd3,
    PH_PAUSE  = 3'd4,
    PH_HALTED = 3'd5
  } phase_t;

  localparam logic [1:0] GRP_A = 2'b00;
  localparam logic [1:0] GRP_B = 2'b01;
  localparam logic [1:0] GRP_C = 2'b10;

  // Top bit 0 selects group A regardless of the next bit.
  function automatic logic [1:0] group_of(input logic [1:0] top);
    if (!top[1])     return GRP_A;
    else if (!top[0]) return GRP_B;
    else             return GRP_C;
  endfunction

endpackage

// File: rtl/cpu_timing_seq_beat_len_lut.sv
// beat_len_lut: combinational group -> last execute-beat index (N-1).
//   group    in  2       : group code (GRP_A/B/C)
//   last_idx out BEAT_W  : index of the final EXEC beat for that group
// Beat counts are elaboration constants; an out-of-range count stops elaboration.
module beat_len_lut
  import cpu_timing_pkg::*;
#(
  parameter int BEAT_W = 3,
  parameter int NA     = 1,
  parameter int NB     = 2,
  parameter int NC     = 3
) (
  input  logic [1:0]        group,
  output logic [BEAT_W-1:0] last_idx
);

  localparam int MAX_N = 1 << BEAT_W;

  if (NA < 1 || NA > MAX_N || NB < 1 || NB > MAX_N || NC < 1 || NC > MAX_N) begin : g_bad_n
    $error("beat_len_lut: every group beat count must lie in 1..2**BEAT_W");
  end

  localparam logic [BEAT_W-1:0] LAST_A = BEAT_W'(NA - 1);
  localparam logic [BEAT_W-1:0] LAST_B = BEAT_W'(NB - 1);
  localparam logic [BEAT_W-1:0] LAST_C = BEAT_W'(NC - 1);

  always_comb begin
    case (group)
      GRP_B:   last_idx = LAST_B;
      GRP_C:   last_idx = LAST_C;
      default: last_idx = LAST_A;  // unused code 11 behaves as group A
    endcase
  end

endmodule

// File: rtl/cpu_timing_seq.sv
// cpu_timing_seq: sequences FETCH, DECODE and a group-dependent number of EXEC
// beats per instruction, with wait-state hold, single-step and halt at
// instruction boundaries.
//   clk, reset (async, active-low)
//   ins        in  : instruction word, captured in FETCH
//   hold       in  : freezes all state while high; retire forced low
//   step_mode  in  : pause after every instruction
//   step       in  : pulse releasing PAUSE
//   halt_req   in  : level request to halt at the next boundary
//   resume     in  : pulse leaving HALTED (only with halt_req low)
//   ir         out : latched instruction
//   phase      out : current phase code (phase_t)
//   group      out : group of the latched instruction
//   beat       out : 0-based EXEC beat, zero elsewhere
//   last_beat  out : final EXEC beat of the instruction
//   retire     out : one-cycle pulse after the last beat
//   retired    out : retired-instruction count, wrapping
module cpu_timing_seq
  import cpu_timing_pkg::*;
#(
  parameter int INS_W  = 16,
  parameter int BEAT_W = 3,
  parameter int NA     = 1,
  parameter int NB     = 2,
  parameter int NC     = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  input  logic              hold,
  input  logic              step_mode,
  input  logic              step,
  input  logic              halt_req,
  input  logic              resume,
  output logic [INS_W-1:0]  ir,
  output logic [2:0]        phase,
  output logic [1:0]        group,
  output logic [BEAT_W-1:0] beat,
  output logic              last_beat,
  output logic              retire,
  output logic [CNT_W-1:0]  retired
);

  phase_t              state, state_d;
  logic [BEAT_W-1:0]   beat_d;
  logic [BEAT_W-1:0]   last_idx;
  logic                load_ir;
  logic                boundary;

  beat_len_lut #(
    .BEAT_W(BEAT_W), .NA(NA), .NB(NB), .NC(NC)
  ) u_lut (
    .group   (group),
    .last_idx(last_idx)
  );

  assign phase     = state;
  assign last_beat = (state == PH_EXEC) && (beat == last_idx);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d  = state;
    beat_d   = beat;
    load_ir  = 1'b0;
    boundary = 1'b0;
    // Hold freezes everything; pulses arriving under hold are deliberately dropped.
    if (!hold) begin
      case (state)
        PH_RESET:  state_d = PH_FETCH;
        PH_FETCH: begin
          load_ir = 1'b1;
          state_d = PH_DECODE;
        end
        PH_DECODE: begin
          beat_d  = '0;
          state_d = PH_EXEC;
        end
        PH_EXEC: begin
          if (last_beat) begin
            boundary = 1'b1;
            beat_d   = '0;
            if (halt_req)       state_d = PH_HALTED;
            else if (step_mode) state_d = PH_PAUSE;
            else                state_d = PH_FETCH;
          end else begin
            beat_d = beat + BEAT_W'(1);
          end
        end
        PH_PAUSE: begin
          if (halt_req)  state_d = PH_HALTED;
          else if (step) state_d = PH_FETCH;
        end
        PH_HALTED: begin
          if (resume && !halt_req) state_d = PH_FETCH;
        end
        default:   state_d = PH_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= PH_RESET;
      ir      <= '0;
      group   <= GRP_A;
      beat    <= '0;
      retire  <= 1'b0;
      retired <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state  <= state_d;
      beat   <= beat_d;
      retire <= boundary;
      if (load_ir) begin
        ir    <= ins;
        // Group is taken straight from the incoming word so it is valid during DECODE.
        group <= group_of(ins[INS_W-1 -: 2]);
      end
      if (boundary) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_timing_seq.sv
// Self-checking bench for cpu_timing_seq. A position-in-instruction reference
// model (FETCH=0, DECODE=1, EXEC beats 2..L-1 with L = 2+N) plus a run/pause/halt
// mode predicts every output each cycle. A second instance with CNT_W=2
// exercises counter wrap.
module tb_cpu_timing_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] ins = '0;
  logic        hold = 1'b0, step_mode = 1'b0, step = 1'b0, halt_req = 1'b0, resume = 1'b0;

  logic [15:0] ir, ir2;
  logic [2:0]  phase, phase2;
  logic [1:0]  group, group2;
  logic [2:0]  beat, beat2;
  logic        last_beat, last_beat2, retire, retire2;
  logic [15:0] retired;
  logic [1:0]  retired2;

  cpu_timing_seq u_dut (
    .clk(clk), .reset(reset), .ins(ins), .hold(hold), .step_mode(step_mode),
    .step(step), .halt_req(halt_req), .resume(resume), .ir(ir), .phase(phase),
    .group(group), .beat(beat), .last_beat(last_beat), .retire(retire), .retired(retired)
  );

  cpu_timing_seq #(.CNT_W(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .ins(ins), .hold(hold), .step_mode(step_mode),
    .step(step), .halt_req(halt_req), .resume(resume), .ir(ir2), .phase(phase2),
    .group(group2), .beat(beat2), .last_beat(last_beat2), .retire(retire2), .retired(retired2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 run, 1 paused, 2 halted.
  bit          m_started;
  int          m_pos, m_len, m_mode, m_grp, m_retired;
  logic [15:0] m_ir;
  bit          m_retire;

  function automatic int n_of(input int grp);
    return (grp == 0) ? 1 : (grp == 1) ? 2 : 3;
  endfunction

  task automatic model_reset();
    m_started = 0; m_pos = 0; m_len = 3; m_mode = 0; m_grp = 0;
    m_retired = 0; m_ir = '0; m_retire = 0;
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    m_retire = 0;
    if (hold) return;
    if (!m_started) begin
      m_started = 1; m_pos = 0; m_mode = 0;
    end else if (m_mode == 1) begin
      if (halt_req)  m_mode = 2;
      else if (step) begin m_mode = 0; m_pos = 0; end
    end else if (m_mode == 2) begin
      if (resume && !halt_req) begin m_mode = 0; m_pos = 0; end
    end else if (m_pos == 0) begin
      m_ir  = ins;
      m_grp = !ins[15] ? 0 : !ins[14] ? 1 : 2;
      m_len = 2 + n_of(m_grp);
      m_pos = 1;
    end else if (m_pos < m_len - 1) begin
      m_pos++;
    end else begin
      m_retire = 1;
      m_retired++;
      m_pos = 0;
      m_mode = halt_req ? 2 : step_mode ? 1 : 0;
    end
  endtask

  function automatic int exp_phase();
    if (!m_started)       return 0;
    else if (m_mode == 1) return 4;
    else if (m_mode == 2) return 5;
    else if (m_pos == 0)  return 1;
    else if (m_pos == 1)  return 2;
    else                  return 3;
  endfunction

  task automatic check_outputs();
    int ph, bt;
    bit lb;
    ph = exp_phase();
    bt = (ph == 3) ? m_pos - 2 : 0;
    lb = (ph == 3) && (m_pos == m_len - 1);
    check("phase",      phase,      ph);
    check("beat",       beat,       bt);
    check("last_beat",  last_beat,  lb);
    check("retire",     retire,     m_retire);
    check("retired",    retired,    m_retired & 32'hFFFF);
    check("ir",         ir,         m_ir);
    if (ph == 3) check("group", group, m_grp);
    check("phase_w2",   phase2,     ph);
    check("retire_w2",  retire2,    m_retire);
    check("retired_w2", retired2,   m_retired & 3);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    bit found;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;

    // Free run of group-A instructions.
    ins = 16'h0000;
    repeat (16) cycle();

    // Alternate B and C instructions.
    repeat (24) begin
      ins = m_retired[0] ? 16'hC000 : 16'h8000;
      cycle();
    end

    // Hold for 3 cycles on EXEC beat 1 of a C instruction.
    ins = 16'hC000;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_phase() == 3 && m_grp == 2 && m_pos == 3) found = 1;
      else cycle();
    end
    if (!found) check("wait_c_beat1", 0, 1);
    hold = 1'b1;
    repeat (3) cycle();
    hold = 1'b0;
    repeat (8) cycle();

    // Step mode with a step pulse coincident with hold.
    step_mode = 1'b1;
    repeat (6) cycle();
    hold = 1'b1; step = 1'b1;
    cycle();
    hold = 1'b0; step = 1'b0;
    repeat (2) cycle();
    step = 1'b1; cycle(); step = 1'b0;
    repeat (6) cycle();
    step_mode = 1'b0;
    step = 1'b1; cycle(); step = 1'b0;

    // Halt mid-EXEC, resume blocked while halt_req stays high.
    ins = 16'hC000;
    repeat (3) cycle();
    halt_req = 1'b1;
    repeat (6) cycle();
    resume = 1'b1; cycle(); resume = 1'b0;
    repeat (2) cycle();
    halt_req = 1'b0;
    cycle();
    resume = 1'b1; cycle(); resume = 1'b0;
    repeat (6) cycle();

    // Randomised segments with different hold density and step mode.
    for (int seg = 0; seg < 4; seg++) begin
      step_mode = (seg >= 2);
      repeat (500) begin
        ins    = 16'($urandom);
        hold   = ($urandom_range(0, 99) < (seg[0] ? 30 : 8));
        step   = ($urandom_range(0, 3) == 0);
        resume = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 99) < 5) halt_req = ~halt_req;
        cycle();
      end
    end

    // Return to running EXEC, then assert reset asynchronously mid-instruction.
    hold = 1'b0; halt_req = 1'b0; step_mode = 1'b0; ins = 16'hC000;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (exp_phase() == 3) found = 1;
      else begin
        step = 1'b1; resume = 1'b1;
        cycle();
      end
    end
    step = 1'b0; resume = 1'b0;
    if (!found) check("wait_exec", 0, 1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_phase",      phase,    0);
    check("async_retired",    retired,  0);
    check("async_retired_w2", retired2, 0);
    check("async_beat",       beat,     0);
    repeat (2) cycle();
    reset = 1'b1;
    ins = 16'h8000;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_timing_seq.md
# cpu_timing_seq

Parametrised CPU timing generator: sequences the fetch, decode and variable-length execute beats for every instruction, with per-group beat counts, wait-state hold, single-step and halt at instruction boundaries. Sits between instruction memory and the control-signal decoder. The control decoder consumes `phase`/`beat`/`group` instead of a fixed 4-bit state code.

## Interface
- `INS_W`, 16: instruction width. Group is taken from `ins[INS_W-1:INS_W-2]`.
- `BEAT_W`, 3: beat counter width. Maximum execute beats is 2^BEAT_W.
- `NA`, 1: execute beats for group A (`ins[INS_W-1]==0`). Range 1..2^BEAT_W.
- `NB`, 2: execute beats for group B (top bits `10`). Same range.
- `NC`, 3: execute beats for group C (top bits `11`). Same range.
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `ins` in INS_W: instruction word from memory. Sampled in FETCH.
- `hold` in 1: memory wait. Freezes all state while high.
- `step_mode` in 1: when high, pause after each instruction.
- `step` in 1: single-cycle pulse that releases PAUSE.
- `halt_req` in 1: level request to stop at the next instruction boundary.
- `resume` in 1: pulse that leaves HALTED.
- `ir` out INS_W: latched instruction.
- `phase` out 3: 0 RESET, 1 FETCH, 2 DECODE, 3 EXEC, 4 PAUSE, 5 HALTED.
- `group` out 2: 00 A, 01 B, 10 C. Valid from DECODE onward.
- `beat` out BEAT_W: execute beat index, 0-based. Zero outside EXEC.
- `last_beat` out 1: high during the final EXEC beat.
- `retire` out 1: one-cycle pulse on the cycle after the last beat completes.
- `retired` out CNT_W: count of retired instructions. Wraps modulo 2^CNT_W.

## Operation
- States and codes:
  - RESET (code 0)
  - FETCH (code 1)
  - DECODE (code 2)
  - EXEC (code 3)
  - PAUSE (code 4)
  - HALTED (code 5)
- `phase` is a registered state code. `last_beat` is combinational from state, beat and group.
- Reset values: state RESET, `ir`=0, `group`=00, `beat`=0, `retire`=0, `retired`=0.
- RESET → FETCH unconditionally.
- FETCH → DECODE. `ir` <= `ins` on this transition.
- DECODE: set `group` from the top bits of `ir`, then go to EXEC with `beat`=0.
- EXEC, when `beat` < N(group)−1: `beat`++ and stay in EXEC.
- EXEC, on the last beat, the boundary decision in priority order:
  1. `halt_req` → HALTED
  2. `step_mode` → PAUSE
  3. otherwise → FETCH
- On leaving the last beat by any boundary path: pulse `retire`, increment `retired`, clear `beat`.
- PAUSE → FETCH on `step`. `halt_req` in PAUSE → HALTED.
- HALTED → FETCH on `resume`, only when `halt_req` is low. Otherwise stay.
- `resume` outside HALTED and `step` outside PAUSE are ignored.
- `hold` high: no state, beat, `ir` or counter update, and `retire` is forced low. Hold overrides every other input, including `step` and `resume` pulses, which are lost.
- Group beat counts are fixed at elaboration. Elaboration fails (generate-time error) if any N is 0 or exceeds 2^BEAT_W.

## Timing
- Instruction latency without hold: 2 + N(group) cycles. Back-to-back issue, no bubble, so FETCH follows the last EXEC beat directly.
- Defaults give A = 3 cycles, B = 4, C = 5.
- First FETCH occurs on the second rising edge after reset deasserts.
- `retire` is asserted in the cycle whose state is FETCH, PAUSE or HALTED, immediately after the last beat.
- Reset asserted mid-instruction: all outputs go to reset values asynchronously. The partial instruction is not counted.
- `retired` wrap: from 2^CNT_W−1, the next retire gives 0, and `retire` still pulses.
- `hold` asserted on the last beat: the boundary decision uses `halt_req`/`step_mode` sampled on the first non-hold cycle.

## Structure
- Shared package `cpu_timing_pkg` holds:
  - the phase enumeration/localparams (RESET..HALTED);
  - group code constants.
- The control decoder imports the same package.
- Natural sub-module: `beat_len_lut`, a combinational group → beat count N mapping producing the last-beat index. Everything else lives in one sequential block plus output logic.

## Test plan
- Reset release, `ins`=16'h0000, free run: `phase` sequence 0,1,2,3,1,2,3…; `retire` every 3 cycles; `retired`=4 after 12 cycles past the first FETCH.
- Alternating `ins`=16'h8000 then 16'hC000 with defaults: EXEC lasts 2 then 3 beats; `beat` 0,1 then 0,1,2; `last_beat` on beats 1 and 2 respectively.
- `hold` high for 3 cycles during EXEC beat 1 of a C instruction: `beat` stays 1 for 4 cycles, no `retire`; total instruction length 8 cycles.
- `step_mode`=1: after each instruction `phase`=4 until a `step` pulse. A `step` coincident with `hold` is ignored and PAUSE persists.
- `halt_req` asserted mid-EXEC: the instruction completes, `retire` pulses, `phase`=5. `resume` with `halt_req` still high stays halted. `resume` after `halt_req` drops returns to FETCH.
- `CNT_W`=2 build: after 4 retires, `retired` wraps from 3 to 0. Reset asserted mid-EXEC gives `phase`=0 and `retired`=0 immediately.
